// File: rtl/siso_frame_arbiter_if.sv
// Bundle of requester handshakes and serial-link outputs for siso_frame_arbiter.
// The master side drives the requests; the slave side is the arbiter itself.
interface siso_frame_arbiter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             serial_out;
    logic             busy;
    logic             frame_start;
    logic             grant_id;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, serial_out, busy, frame_start, grant_id
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, serial_out, busy, frame_start, grant_id
    );
endinterface

// File: rtl/siso_frame_arbiter.sv
// Round-robin arbiter sharing one MSB-first shift-out register between two requesters;
// each frame is WIDTH bits followed by GAP_CYCLES idle-low cycles.
module siso_frame_arbiter #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned GAP_CYCLES = 1
) (
    input logic                   clk,
    input logic                   reset,
    siso_frame_arbiter_if.slave   io_bus
);
    localparam int unsigned BitW = $clog2(WIDTH + 1);
    localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);
    localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [WIDTH-1:0]  r_shift;
    logic [BitW-1:0]   r_bit_cnt;
    logic [GapW-1:0]   r_gap_cnt;
    logic              r_rr_ptr;
    logic              r_grant_id;

    logic w_idle;
    logic w_sel1;
    logic w_rdy0;
    logic w_rdy1;
    logic w_hs;

    always_comb begin
        w_idle    = (r_state == StIdle);
        // Requester 1 wins when alone, or on a tie when the pointer favours it.
        w_sel1    = io_bus.req1_valid & (~io_bus.req0_valid | r_rr_ptr);
        w_rdy0    = w_idle & io_bus.req0_valid & ~w_sel1;
        w_rdy1    = w_idle & io_bus.req1_valid & w_sel1;
        w_hs      = w_rdy0 | w_rdy1;
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_hs) w_state_d = StShift;
            StShift: if (r_bit_cnt == BitLast) w_state_d = (GAP_CYCLES > 0) ? StGap : StIdle;
            StGap:   if (r_gap_cnt == GapLast) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_rr_ptr   <= 1'b0;
            r_grant_id <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_hs) begin
                        r_shift    <= w_rdy1 ? io_bus.req1_data : io_bus.req0_data;
                        r_grant_id <= w_rdy1;
                        r_rr_ptr   <= ~w_rdy1;
                        r_bit_cnt  <= '0;
                    end
                end
                StShift: begin
                    r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + BitW'(1);
                    // Held at zero while shifting so the gap always starts from a clean count.
                    r_gap_cnt <= '0;
                end
                StGap: begin
                    r_gap_cnt <= r_gap_cnt + GapW'(1);
                end
                default: begin
                    r_bit_cnt <= '0;
                end
            endcase
        end
    end

    assign io_bus.req0_ready  = w_rdy0;
    assign io_bus.req1_ready  = w_rdy1;
    assign io_bus.serial_out  = (r_state == StShift) & r_shift[WIDTH-1];
    assign io_bus.busy        = ~w_idle;
    assign io_bus.frame_start = (r_state == StShift) & (r_bit_cnt == '0);
    assign io_bus.grant_id    = r_grant_id;
endmodule

// File: tb/tb_siso_frame_arbiter.sv
// Bench for siso_frame_arbiter: WIDTH=4/GAP=1 and WIDTH=8/GAP=0 instances against a
// timing-based reference model (cycles elapsed since the last accepted word).
module tb_siso_frame_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a;
    logic       rst_b;
    bit         v0 [2];
    bit         v1 [2];
    logic [7:0] d0 [2];
    logic [7:0] d1 [2];

    siso_frame_arbiter_if #(.WIDTH(4)) if_a ();
    siso_frame_arbiter_if #(.WIDTH(8)) if_b ();

    assign if_a.req0_valid = v0[0];
    assign if_a.req1_valid = v1[0];
    assign if_a.req0_data  = d0[0][3:0];
    assign if_a.req1_data  = d1[0][3:0];
    assign if_b.req0_valid = v0[1];
    assign if_b.req1_valid = v1[1];
    assign if_b.req0_data  = d0[1];
    assign if_b.req1_data  = d1[1];

    siso_frame_arbiter #(.WIDTH(4), .GAP_CYCLES(1)) dut_a (
        .clk    (clk),
        .reset  (rst_a),
        .io_bus (if_a.slave)
    );

    siso_frame_arbiter #(.WIDTH(8), .GAP_CYCLES(0)) dut_b (
        .clk    (clk),
        .reset  (rst_b),
        .io_bus (if_b.slave)
    );

    // Packed as {rdy0, rdy1, serial, busy, frame_start, grant_id}.
    logic [5:0] obs_v [2];
    assign obs_v[0] = {if_a.req0_ready, if_a.req1_ready, if_a.serial_out, if_a.busy,
                       if_a.frame_start, if_a.grant_id};
    assign obs_v[1] = {if_b.req0_ready, if_b.req1_ready, if_b.serial_out, if_b.busy,
                       if_b.frame_start, if_b.grant_id};

    int errors = 0;
    int checks = 0;

    // Reference model: since = cycles since acceptance (0 = idle and able to accept).
    int         m_since [2];
    logic [7:0] m_word  [2];
    bit         m_rr    [2];
    bit         m_grant [2];
    bit         hs      [2];
    bit         wn      [2];
    logic [5:0] exp_v   [2];

    function automatic int wof(input int d);
        return (d == 0) ? 4 : 8;
    endfunction

    function automatic int gof(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    task automatic model_eval();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            int w;
            int s;
            bit win;
            bit sbit;
            w   = wof(d);
            s   = m_since[d];
            win = (v0[d] && v1[d]) ? m_rr[d] : v1[d];
            hs[d] = (s == 0) && (v0[d] || v1[d]);
            wn[d] = win;
            sbit  = (s >= 1 && s <= w) ? m_word[d][w - s] : 1'b0;
            exp_v[d] = {hs[d] && !win, hs[d] && win, sbit, s != 0, s == 1, m_grant[d]};
        end
    endtask

    task automatic model_commit();
        for (int d = 0; d < 2; d++) begin
            logic r;
            r = (d == 0) ? rst_a : rst_b;
            if (r) begin
                m_since[d] = 0;
                m_word[d]  = '0;
                m_rr[d]    = 1'b0;
                m_grant[d] = 1'b0;
            end else if (hs[d]) begin
                m_since[d] = 1;
                m_word[d]  = wn[d] ? d1[d] : d0[d];
                if (d == 0) m_word[d] = m_word[d] & 8'h0F;
                m_grant[d] = wn[d];
                m_rr[d]    = !wn[d];
            end else if (m_since[d] != 0) begin
                m_since[d]++;
                if (m_since[d] > wof(d) + gof(d)) m_since[d] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        for (int i = 0; i < 30; i++) begin
            if (m_since[0] == 0 && m_since[1] == 0) break;
            model_eval();
            model_commit();
        end
    endtask

    task automatic reset_dut(input int d);
        if (d == 0) rst_a = 1'b1; else rst_b = 1'b1;
        model_eval();
        model_commit();
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        model_eval();
        model_commit();
        rst_a = 1'b0;
        rst_b = 1'b0;
        model_eval();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_v[d] !== 6'b0) begin
                errors++;
                $display("FAIL reset dut=%0d got=%b want=%b", d, obs_v[d], 6'b0);
            end
        end
        model_commit();
    endtask

    task automatic test_single_frame();
        logic [3:0] pat;
        pat   = 4'b1011;
        v0[0] = 1'b1;
        d0[0] = 8'h0B;
        for (int c = 0; c <= 6; c++) begin
            model_eval();
            checks++;
            if (obs_v[0] !== exp_v[0]) begin
                errors++;
                $display("FAIL single_frame cyc=%0d got=%b want=%b", c, obs_v[0], exp_v[0]);
            end
            if (c >= 1 && c <= 4) begin
                checks++;
                if (obs_v[0][3] !== pat[4 - c]) begin
                    errors++;
                    $display("FAIL single_frame_bit cyc=%0d got=%b want=%b", c, obs_v[0][3],
                             pat[4 - c]);
                end
            end
            if (c == 6) begin
                checks++;
                if (obs_v[0][5] !== 1'b1) begin
                    errors++;
                    $display("FAIL single_frame_rearm got=%b want=1", obs_v[0][5]);
                end
            end
            model_commit();
        end
        v0[0] = 1'b0;
        settle();
    endtask

    task automatic test_tie();
        bit gl [$];
        reset_dut(0);
        v0[0] = 1'b1;
        v1[0] = 1'b1;
        d0[0] = 8'h0A;
        d1[0] = 8'h05;
        for (int c = 0; c < 16; c++) begin
            bit h;
            bit w;
            model_eval();
            checks++;
            if (obs_v[0] !== exp_v[0] || (obs_v[0][5] && obs_v[0][4])) begin
                errors++;
                $display("FAIL tie cyc=%0d got=%b want=%b", c, obs_v[0], exp_v[0]);
            end
            if (obs_v[0][1]) gl.push_back(obs_v[0][0]);
            h = hs[0];
            w = wn[0];
            model_commit();
            if (h && !w) v0[0] = 1'b0;
            if (h && w) v1[0] = 1'b0;
        end
        checks++;
        if (gl.size() != 2 || gl[0] !== 1'b0 || gl[1] !== 1'b1) begin
            errors++;
            $display("FAIL tie_order got=%p want='{0,1}", gl);
        end
        settle();
    endtask

    task automatic test_contention();
        int fs_cyc [$];
        bit fs_gid [$];
        reset_dut(0);
        v0[0] = 1'b1;
        v1[0] = 1'b1;
        for (int c = 0; c < 60 && fs_cyc.size() < 6; c++) begin
            d0[0] = 8'($urandom);
            d1[0] = 8'($urandom);
            model_eval();
            checks++;
            if (obs_v[0] !== exp_v[0]) begin
                errors++;
                $display("FAIL contention cyc=%0d got=%b want=%b", c, obs_v[0], exp_v[0]);
            end
            if (obs_v[0][1]) begin
                fs_cyc.push_back(c);
                fs_gid.push_back(obs_v[0][0]);
            end
            model_commit();
        end
        checks++;
        if (fs_cyc.size() != 6) begin
            errors++;
            $display("FAIL contention_frames got=%0d want=6", fs_cyc.size());
        end
        for (int k = 0; k < fs_cyc.size(); k++) begin
            checks++;
            if (fs_gid[k] !== 1'(k % 2)) begin
                errors++;
                $display("FAIL contention_gid frame=%0d got=%b want=%0d", k, fs_gid[k], k % 2);
            end
            if (k > 0) begin
                checks++;
                if (fs_cyc[k] - fs_cyc[k-1] != 6) begin
                    errors++;
                    $display("FAIL contention_spacing frame=%0d got=%0d want=6", k,
                             fs_cyc[k] - fs_cyc[k-1]);
                end
            end
        end
        v0[0] = 1'b0;
        v1[0] = 1'b0;
        settle();
    endtask

    task automatic test_lone_req1();
        int frames;
        frames = 0;
        reset_dut(0);
        v1[0] = 1'b1;
        for (int c = 0; c < 40 && frames < 3; c++) begin
            d1[0] = 8'($urandom);
            model_eval();
            checks++;
            if (obs_v[0] !== exp_v[0]) begin
                errors++;
                $display("FAIL lone_req1 cyc=%0d got=%b want=%b", c, obs_v[0], exp_v[0]);
            end
            if (obs_v[0][1]) begin
                frames++;
                checks++;
                if (obs_v[0][0] !== 1'b1) begin
                    errors++;
                    $display("FAIL lone_req1_gid cyc=%0d got=%b want=1", c, obs_v[0][0]);
                end
            end
            model_commit();
        end
        checks++;
        if (frames != 3) begin
            errors++;
            $display("FAIL lone_req1_frames got=%0d want=3", frames);
        end
        v1[0] = 1'b0;
        settle();
    endtask

    task automatic test_reset_mid();
        reset_dut(0);
        v0[0] = 1'b1;
        d0[0] = 8'h0F;
        for (int c = 0; c < 10 && m_since[0] != 3; c++) begin
            model_eval();
            checks++;
            if (obs_v[0] !== exp_v[0]) begin
                errors++;
                $display("FAIL reset_mid_pre cyc=%0d got=%b want=%b", c, obs_v[0], exp_v[0]);
            end
            model_commit();
        end
        rst_a = 1'b1;
        model_eval();
        model_commit();
        rst_a = 1'b0;
        v0[0] = 1'b0;
        model_eval();
        checks++;
        if (obs_v[0] !== exp_v[0] || obs_v[0][3:2] !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_abort got=%b want=%b", obs_v[0], exp_v[0]);
        end
        model_commit();
        v0[0] = 1'b1;
        v1[0] = 1'b1;
        d0[0] = 8'h03;
        d1[0] = 8'h0C;
        model_eval();
        checks++;
        if (obs_v[0] !== exp_v[0] || obs_v[0][5] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_tie got=%b want=%b", obs_v[0], exp_v[0]);
        end
        model_commit();
        v0[0] = 1'b0;
        v1[0] = 1'b0;
        settle();
    endtask

    task automatic test_no_gap();
        logic [7:0] pat;
        pat = 8'h81;
        reset_dut(1);
        v0[1] = 1'b1;
        d0[1] = 8'h81;
        for (int c = 0; c < 22; c++) begin
            model_eval();
            checks++;
            if (obs_v[1] !== exp_v[1]) begin
                errors++;
                $display("FAIL no_gap cyc=%0d got=%b want=%b", c, obs_v[1], exp_v[1]);
            end
            if (c >= 1 && c <= 8) begin
                checks++;
                if (obs_v[1][3] !== pat[8 - c]) begin
                    errors++;
                    $display("FAIL no_gap_bit cyc=%0d got=%b want=%b", c, obs_v[1][3],
                             pat[8 - c]);
                end
            end
            if (c == 9) begin
                checks++;
                if (obs_v[1][5] !== 1'b1) begin
                    errors++;
                    $display("FAIL no_gap_rearm got=%b want=1", obs_v[1][5]);
                end
            end
            model_commit();
        end
        v0[1] = 1'b0;
        settle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                v0[d] = ($urandom_range(0, 3) != 0);
                v1[d] = ($urandom_range(0, 2) != 0);
                d0[d] = 8'($urandom);
                d1[d] = 8'($urandom);
            end
            rst_a = ($urandom_range(0, 63) == 0);
            rst_b = ($urandom_range(0, 63) == 0);
            model_eval();
            for (int d = 0; d < 2; d++) begin
                logic r;
                r = (d == 0) ? rst_a : rst_b;
                if (!r) begin
                    checks++;
                    if (obs_v[d] !== exp_v[d]) begin
                        errors++;
                        $display("FAIL random dut=%0d cyc=%0d got=%b want=%b", d, c, obs_v[d],
                                 exp_v[d]);
                    end
                end
            end
            model_commit();
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int d = 0; d < 2; d++) begin
            v0[d] = 1'b0;
            v1[d] = 1'b0;
        end
        settle();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            v0[d]      = 1'b0;
            v1[d]      = 1'b0;
            d0[d]      = '0;
            d1[d]      = '0;
            m_since[d] = 0;
            m_word[d]  = '0;
            m_rr[d]    = 1'b0;
            m_grant[d] = 1'b0;
        end
        rst_a = 1'b1;
        rst_b = 1'b1;
        test_reset();
        test_single_frame();
        test_tie();
        test_contention();
        test_lone_req1();
        test_reset_mid();
        test_no_gap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
